// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the teaching-CPU control sequencer: opcodes, console modes,
// sequencer states, beat codes, 74181 function selects and the decoded control bundle.
package cpu_seq_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
        OP_INC = 4'h4, OP_LD  = 4'h5, OP_ST  = 4'h6, OP_JC  = 4'h7,
        OP_JZ  = 4'h8, OP_JMP = 4'h9, OP_OUT = 4'hA, OP_OR  = 4'hB,
        OP_CMP = 4'hC, OP_MOV = 4'hD, OP_STP = 4'hE, OP_RSV = 4'hF
    } opcode_t;

    localparam logic [2:0] MODE_RUN  = 3'b000;
    localparam logic [2:0] MODE_WMEM = 3'b001;
    localparam logic [2:0] MODE_RMEM = 3'b010;
    localparam logic [2:0] MODE_RREG = 3'b011;
    localparam logic [2:0] MODE_WREG = 3'b100;
    localparam logic [2:0] MODE_STEP = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CON0, ST_CON1, ST_EXEC, ST_HALT
    } state_t;

    localparam logic [2:0] W1 = 3'b001;
    localparam logic [2:0] W2 = 3'b010;
    localparam logic [2:0] W3 = 3'b100;

    localparam logic [3:0] S_PASS_A = 4'b1111;
    localparam logic [3:0] S_PASS_B = 4'b1010;
    localparam logic [3:0] S_ADD    = 4'b1001;
    localparam logic [3:0] S_SUB    = 4'b0110;
    localparam logic [3:0] S_AND    = 4'b1011;
    localparam logic [3:0] S_OR     = 4'b1110;
    localparam logic [3:0] S_INC    = 4'b0000;

    // halt is internal only: it marks the STP beat so the sequencer parks in HALT.
    typedef struct packed {
        logic       selctl, drw, lpc, pcinc, pcadd, lar, arinc, lir;
        logic       ldz, ldc, cin, m, memw, abus, sbus, mbus;
        logic       short_beat, long_beat, halt;
        logic [3:0] s;
    } ctl_t;

endpackage

// File: rtl/cpu_seq_decode.sv
// Instruction decoder: opcode, beat and ALU flags to the datapath control bundle.
// Extended opcodes (OUT/OR/CMP/MOV) collapse to NOP when EXT_ISA is 0.
module cpu_seq_decode
    import cpu_seq_pkg::*;
#(
    parameter int EXT_ISA = 1
) (
    input  logic [3:0] opcode,
    input  logic [2:0] w,
    input  logic       c,
    input  logic       z,
    output ctl_t       ctl
);

    localparam bit EXT = (EXT_ISA != 0);

    always_comb begin
        // NOTE: the all-zero default ahead of the case keeps every field assigned on every path, so no latch is inferred.
        ctl = '0;
        if (w == W1) begin
            ctl.lir   = 1'b1;
            ctl.pcinc = 1'b1;
        end else if (w == W2) begin
            case (opcode_t'(opcode))
                OP_ADD: begin ctl.s = S_ADD; ctl.cin = 1'b1; ctl.abus = 1'b1; ctl.drw = 1'b1; ctl.ldz = 1'b1; ctl.ldc = 1'b1; end
                OP_SUB: begin ctl.s = S_SUB; ctl.abus = 1'b1; ctl.drw = 1'b1; ctl.ldz = 1'b1; ctl.ldc = 1'b1; end
                OP_AND: begin ctl.s = S_AND; ctl.m = 1'b1; ctl.abus = 1'b1; ctl.drw = 1'b1; ctl.ldz = 1'b1; end
                OP_INC: begin ctl.s = S_INC; ctl.abus = 1'b1; ctl.drw = 1'b1; ctl.ldz = 1'b1; ctl.ldc = 1'b1; end
                OP_LD:  begin ctl.s = S_PASS_B; ctl.m = 1'b1; ctl.abus = 1'b1; ctl.lar = 1'b1; ctl.long_beat = 1'b1; end
                OP_ST:  begin ctl.s = S_PASS_A; ctl.m = 1'b1; ctl.abus = 1'b1; ctl.lar = 1'b1; ctl.long_beat = 1'b1; end
                OP_JC:  ctl.pcadd = c;
                OP_JZ:  ctl.pcadd = z;
                OP_JMP: begin ctl.s = S_PASS_A; ctl.m = 1'b1; ctl.abus = 1'b1; ctl.lpc = 1'b1; end
                OP_OUT: if (EXT) begin ctl.s = S_PASS_B; ctl.m = 1'b1; ctl.abus = 1'b1; end
                OP_OR:  if (EXT) begin ctl.s = S_OR; ctl.m = 1'b1; ctl.abus = 1'b1; ctl.drw = 1'b1; ctl.ldz = 1'b1; end
                OP_CMP: if (EXT) begin ctl.s = S_SUB; ctl.ldz = 1'b1; ctl.ldc = 1'b1; end
                OP_MOV: if (EXT) begin ctl.s = S_PASS_B; ctl.m = 1'b1; ctl.abus = 1'b1; ctl.drw = 1'b1; end
                OP_STP: ctl.halt = 1'b1;
                default: ;
            endcase
        end else if (w == W3) begin
            case (opcode_t'(opcode))
                OP_LD:  begin ctl.mbus = 1'b1; ctl.drw = 1'b1; end
                OP_ST:  begin ctl.s = S_PASS_B; ctl.m = 1'b1; ctl.abus = 1'b1; ctl.memw = 1'b1; end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cpu_seq.sv
// Hardwired control sequencer: owns the W1-W3 beat counter, console modes with a
// register-index counter, run/single-step execution and HALT. State moves on falling T3.
module cpu_seq
    import cpu_seq_pkg::*;
#(
    parameter  int NREG    = 4,
    parameter  int EXT_ISA = 1,
    localparam int RW      = $clog2(NREG),
    localparam int IW      = 4 + 2 * RW
) (
    input  logic          T3,
    input  logic          CLR,
    input  logic [2:0]    SW,
    input  logic          START,
    input  logic [IW-1:0] IR,
    input  logic          C,
    input  logic          Z,
    output logic [2:0]    W,
    output logic          SELCTL, DRW, LPC, PCINC, PCADD, LAR, ARINC, LIR, LDZ, LDC,
    output logic          CIN, M, MEMW, ABUS, SBUS, MBUS, SHORT, LONG, STOP,
    output logic [3:0]    S,
    output logic [2*RW-1:0] SEL
);

    state_t          state;
    logic [2:0]      w_q;
    logic [RW-1:0]   idx;
    logic [2:0]      mode;
    logic            hold;

    ctl_t            dec, ctl;
    logic            stop, run_mode, last_beat;
    logic [2*RW-1:0] sel;

    cpu_seq_decode #(.EXT_ISA(EXT_ISA)) u_decode (
        .opcode (IR[IW-1:IW-4]),
        .w      (w_q),
        .c      (C),
        .z      (Z),
        .ctl    (dec)
    );

    // hold parks the sequencer between console beats and after a single-stepped instruction.
    always_comb begin
        ctl      = '0;
        sel      = '0;
        stop     = (state == ST_IDLE) || (state == ST_HALT) || hold;
        run_mode = (mode == MODE_RUN) || (mode == MODE_STEP);
        if (!stop) begin
            case (state)
                ST_CON0, ST_CON1: begin
                    case (mode)
                        MODE_WREG: begin ctl.selctl = 1'b1; ctl.sbus = 1'b1; ctl.drw = 1'b1; sel = {idx, {RW{1'b0}}}; end
                        MODE_RREG: begin ctl.selctl = 1'b1; sel = {idx, idx + RW'(1)}; end
                        MODE_WMEM, MODE_RMEM: begin
                            if (state == ST_CON0) begin
                                ctl.sbus = 1'b1; ctl.lar = 1'b1; ctl.short_beat = 1'b1;
                            end else begin
                                ctl.arinc = 1'b1;
                                ctl.sbus  = (mode == MODE_WMEM);
                                ctl.memw  = (mode == MODE_WMEM);
                                ctl.mbus  = (mode == MODE_RMEM);
                            end
                        end
                        default: begin ctl.sbus = 1'b1; ctl.lpc = 1'b1; ctl.short_beat = 1'b1; end
                    endcase
                end
                ST_EXEC: begin
                    ctl = dec;
                    sel = IR[2*RW-1:0];
                end
                default: ;
            endcase
        end
        last_beat = ((w_q == W2) && !ctl.long_beat) || (w_q == W3);
    end

    always_ff @(negedge T3 or posedge CLR) begin
        if (CLR) begin
            state <= ST_IDLE;
            w_q   <= W1;
            idx   <= '0;
            mode  <= MODE_RUN;
            hold  <= 1'b0;
        end else begin
            if (!stop) begin
                case (w_q)
                    W1:      w_q <= ctl.short_beat ? W1 : W2;
                    W2:      w_q <= ctl.long_beat ? W3 : W1;
                    default: w_q <= W1;
                endcase
            end
            case (state)
                ST_IDLE: if (START && (SW <= MODE_STEP)) begin
                    mode  <= SW;
                    state <= ST_CON0;
                end
                ST_CON0, ST_CON1: begin
                    if (hold) begin
                        if (START) hold <= 1'b0;
                    end else begin
                        if (mode == MODE_WREG)      idx <= idx + RW'(1);
                        else if (mode == MODE_RREG) idx <= idx + RW'(2);
                        if (run_mode) begin
                            state <= ST_EXEC;
                        end else begin
                            state <= ST_CON1;
                            hold  <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    if (hold) begin
                        if (START) hold <= 1'b0;
                    end else if (last_beat) begin
                        if (ctl.halt)               state <= ST_HALT;
                        else if (mode == MODE_STEP) hold  <= 1'b1;
                    end
                end
                ST_HALT: if (START) state <= ST_EXEC;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign W      = w_q;
    assign STOP   = stop;
    assign SEL    = sel;
    assign S      = ctl.s;
    assign SELCTL = ctl.selctl;
    assign DRW    = ctl.drw;
    assign LPC    = ctl.lpc;
    assign PCINC  = ctl.pcinc;
    assign PCADD  = ctl.pcadd;
    assign LAR    = ctl.lar;
    assign ARINC  = ctl.arinc;
    assign LIR    = ctl.lir;
    assign LDZ    = ctl.ldz;
    assign LDC    = ctl.ldc;
    assign CIN    = ctl.cin;
    assign M      = ctl.m;
    assign MEMW   = ctl.memw;
    assign ABUS   = ctl.abus;
    assign SBUS   = ctl.sbus;
    assign MBUS   = ctl.mbus;
    assign SHORT  = ctl.short_beat;
    assign LONG   = ctl.long_beat;

endmodule
